twiddle_fetch: RTL and testbench
================================

Name: twiddle_fetch

Overview:
Consumer side of the per-stage twiddle pointer stream. Each beat accepts one pointer per FFT stage and looks up the Q-format twiddle factor for each pointer in an internal ROM. It optionally conjugates the factors for IFFT mode and presents them to the butterfly datapath through a 2-stage valid/ready pipeline. It also marks the last beat of each stage sweep.

Parameters:
N, 8, FFT size (power of 2, >=4)
NUM_STAGES, $clog2(N), number of FFT stages / pointers per beat
NUM_BUTTERFLIES, N/2, ROM depth, and beats per sweep
DATA_W, 16, signed width of each twiddle component
FRAC_BITS, 8, fractional bits (unity = 2^FRAC_BITS); must be < DATA_W-1

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  pointer beat valid
in_ready  out  1  block can accept a beat
ptr_in  in  NUM_STAGES*$clog2(NUM_BUTTERFLIES)  packed pointers; stage s at slice [s*PW +: PW], PW=$clog2(NUM_BUTTERFLIES)
inverse  in  1  1 = conjugate outputs (IFFT); sampled with the beat
out_valid  out  1  twiddle beat valid
out_ready  in  1  downstream accepts beat
tw_real  out  NUM_STAGES*DATA_W  real parts; stage s at [s*DATA_W +: DATA_W]
tw_imag  out  NUM_STAGES*DATA_W  imag parts, same packing
out_last  out  1  high on final beat of a sweep (beat index NUM_BUTTERFLIES-1)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high on reset.
- ROM contents: ROM[k] = (round(2^FRAC_BITS*cos(2πk/N)), -round(2^FRAC_BITS*sin(2πk/N))), k=0..N/2-1. Built at elaboration. For N=8, FRAC_BITS=8: (256,0), (181,-181), (0,-256), (-181,-181).
- Stage S1 (address register): on an input handshake (in_valid & in_ready), latch ptr_in and inverse, and set s1_valid.
- Stage S2 (data register): when S2 advances, register ROM[ptr] for every stage. If inverse, store imag negated.
  - Negation result: -x computed in DATA_W+1 bits, then saturated to DATA_W. -(-2^(DATA_W-1)) gives 2^(DATA_W-1)-1. This is unreachable with legal parameters but is still required.
- S2 advances when s1_valid & (!out_valid | out_ready).
- S1 accepts when (!s1_valid) | S2 advances.
- in_ready = !s1_valid | (!out_valid | out_ready). This is combinational from out_ready; there is no combinational path from in_valid.
- Latency: a beat accepted at edge t appears on out_valid after edge t+1, i.e. 2 cycles after in_valid is presented. Full throughput (1 beat/cycle) while out_ready = 1.
- Backpressure: while out_valid & !out_ready, tw_real, tw_imag and out_last stay stable. S1 holds one further beat, then in_ready drops. No beat is lost or duplicated.
- Sweep counter: beat_cnt counts output handshakes, 0..NUM_BUTTERFLIES-1, then wraps to 0.
  - out_last = out_valid & (beat_cnt == NUM_BUTTERFLIES-1).
  - inverse has no effect on the counter.
- Simultaneous events: S1 may load a new beat in the same cycle it passes its old beat to S2. An output handshake and an S2 load in the same cycle replace the S2 data.
- Reset values (including reset asserted mid-stream): s1_valid=0, out_valid=0, beat_cnt=0, tw_real=0, tw_imag=0, out_last=0, in_ready=1 on the first cycle after reset. In-flight beats are discarded. Inputs are ignored while reset = 1.
- All pointer values 0..NUM_BUTTERFLIES-1 are legal; the pointer width exactly covers the ROM, so there is no out-of-range case.

Test Plan:
1. N=8, out_ready=1. Stream 4 beats; beat i has all 3 stage pointers = i, inverse=0. Required: outputs (256,0), (181,-181), (0,-256), (-181,-181) for all stages, each 2 cycles after its input. out_last=1 only on the 4th beat.
2. Mixed pointers: stage0=0, stage1=2, stage2=3, inverse=1. Required: stage0 (256,0), stage1 (0,256), stage2 (-181,181).
3. Backpressure: stream 6 beats and drop out_ready for 3 cycles after the first output. Required: output held stable, in_ready=0 once S1 is full, all 6 beats delivered in order, out_last on the 4th beat, beat_cnt=2 at end.
4. Alternate inverse per beat with pointer=1. Required: imag alternates -181, +181; real stays 181.
5. Assert reset for 1 cycle while 2 beats are in flight. Required: next cycle out_valid=0, in_ready=1, outputs 0. The next accepted beat starts at beat_cnt=0.
6. Bubbles: in_valid toggled every other cycle for 8 beats. Required: 8 outputs, each 2 cycles after its input, and out_last on beats 4 and 8.

Source files
------------

// File: rtl/twiddle_fetch.sv
`default_nettype none
// ============================================================================
// Module      : twiddle_fetch
// Description : Consumer side of the per-stage twiddle pointer stream. Each
//               accepted beat carries one ROM pointer per FFT stage. The
//               block looks up the Q-format twiddle factor for every
//               pointer, optionally conjugates it (IFFT), and presents the
//               result through a 2-stage valid/ready pipeline. The final
//               beat of every sweep of NUM_BUTTERFLIES beats is flagged.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   in_valid  in   pointer beat valid
//   in_ready  out  block can accept a beat (combinational from out_ready)
//   ptr_in    in   packed pointers, stage s at [s*PW +: PW]
//   inverse   in   1 = conjugate this beat's factors (IFFT)
//   out_valid out  twiddle beat valid
//   out_ready in   downstream accepts beat
//   tw_real   out  real parts, stage s at [s*DATA_W +: DATA_W]
//   tw_imag   out  imag parts, same packing
//   out_last  out  high on the final beat of a sweep
// ============================================================================
module twiddle_fetch #(
  parameter int N               = 8,
  parameter int NUM_STAGES      = $clog2(N),
  parameter int NUM_BUTTERFLIES = N / 2,
  parameter int DATA_W          = 16,
  parameter int FRAC_BITS       = 8
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [NUM_STAGES*$clog2(NUM_BUTTERFLIES)-1:0]   ptr_in,
  input  logic                                            inverse,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [NUM_STAGES*DATA_W-1:0]                    tw_real,
  output logic [NUM_STAGES*DATA_W-1:0]                    tw_imag,
  output logic                                            out_last
);

  localparam int  c_PW    = $clog2(NUM_BUTTERFLIES);
  localparam int  c_PTR_W = NUM_STAGES * c_PW;
  localparam int  c_TW_W  = NUM_STAGES * DATA_W;
  localparam real c_PI    = 3.14159265358979323846;
  localparam real c_UNITY = real'(1 << FRAC_BITS);

  // --------------------------------------------------------------------------
  // Saturating negation: computed one bit wider, then clamped. Only the most
  // negative input can overflow, and it maps to the most positive value.
  // --------------------------------------------------------------------------
  function automatic logic signed [DATA_W-1:0] f_sat_neg(input logic signed [DATA_W-1:0] x);
    logic [DATA_W:0] w_neg;
    w_neg = -{x[DATA_W-1], x};
    if (w_neg[DATA_W] != w_neg[DATA_W-1]) begin
      f_sat_neg = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      f_sat_neg = w_neg[DATA_W-1:0];
    end
  endfunction

  // --------------------------------------------------------------------------
  // Twiddle ROM, evaluated at elaboration: W_N^k = cos(2pi k/N) - j sin(2pi k/N)
  // scaled by 2^FRAC_BITS, rounded half away from zero.
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_rom_re [NUM_BUTTERFLIES];
  logic [DATA_W-1:0] w_rom_im [NUM_BUTTERFLIES];

  for (genvar gk = 0; gk < NUM_BUTTERFLIES; gk++) begin : g_rom
    localparam real c_ANG  = 2.0 * c_PI * real'(gk) / real'(N);
    localparam real c_RE   = $cos(c_ANG) * c_UNITY;
    localparam real c_IM   = -$sin(c_ANG) * c_UNITY;
    localparam int  c_RE_I = (c_RE >= 0.0) ? $rtoi(c_RE + 0.5) : -$rtoi(0.5 - c_RE);
    localparam int  c_IM_I = (c_IM >= 0.0) ? $rtoi(c_IM + 0.5) : -$rtoi(0.5 - c_IM);
    assign w_rom_re[gk] = DATA_W'(c_RE_I);
    assign w_rom_im[gk] = DATA_W'(c_IM_I);
  end

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic               r_s1_valid;
  logic [c_PTR_W-1:0] r_s1_ptr;
  logic               r_s1_inv;
  logic               r_out_valid;
  logic [c_TW_W-1:0]  r_tw_real;
  logic [c_TW_W-1:0]  r_tw_imag;
  logic [c_PW-1:0]    r_beat_cnt;

  logic               w_s2_adv;
  logic               w_s1_load;
  logic               w_out_hs;
  logic [c_TW_W-1:0]  w_nxt_real;
  logic [c_TW_W-1:0]  w_nxt_imag;

  // S2 is free when empty or when its beat leaves this cycle.
  assign w_s2_adv  = r_s1_valid & (~r_out_valid | out_ready);
  // Equivalent to (!s1_valid | S2 advances); never depends on in_valid.
  assign in_ready  = ~r_s1_valid | ~r_out_valid | out_ready;
  assign w_s1_load = in_valid & in_ready;
  assign w_out_hs  = r_out_valid & out_ready;

  // Per-stage lookup from the S1 pointers, with optional conjugation.
  for (genvar gs = 0; gs < NUM_STAGES; gs++) begin : g_stage
    logic [c_PW-1:0]   w_ptr;
    logic [DATA_W-1:0] w_im;
    assign w_ptr = r_s1_ptr[gs*c_PW +: c_PW];
    assign w_im  = w_rom_im[w_ptr];
    assign w_nxt_real[gs*DATA_W +: DATA_W] = w_rom_re[w_ptr];
    assign w_nxt_imag[gs*DATA_W +: DATA_W] = r_s1_inv ? f_sat_neg(w_im) : w_im;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_ptr    <= '0;
      r_s1_inv    <= 1'b0;
      r_out_valid <= 1'b0;
      r_tw_real   <= '0;
      r_tw_imag   <= '0;
      r_beat_cnt  <= '0;
    end else begin
      // S1: may reload in the same cycle it hands its beat to S2.
      if (w_s1_load) begin
        r_s1_ptr   <= ptr_in;
        r_s1_inv   <= inverse;
        r_s1_valid <= 1'b1;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end

      // S2: a load overrides the simultaneous output handshake.
      if (w_s2_adv) begin
        r_tw_real   <= w_nxt_real;
        r_tw_imag   <= w_nxt_imag;
        r_out_valid <= 1'b1;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end

      // Sweep position counts delivered beats only.
      if (w_out_hs) begin
        if (r_beat_cnt == c_PW'(NUM_BUTTERFLIES - 1)) begin
          r_beat_cnt <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign tw_real   = r_tw_real;
  assign tw_imag   = r_tw_imag;
  assign out_last  = r_out_valid & (r_beat_cnt == c_PW'(NUM_BUTTERFLIES - 1));

endmodule
`default_nettype wire

// File: tb/tb_twiddle_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_twiddle_fetch
// Description : Scoreboard bench for twiddle_fetch (N=8, DATA_W=16,
//               FRAC_BITS=8). Directed scenarios followed by a randomized
//               valid/ready phase; expectations come from the twiddle table
//               and simple queue-occupancy rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twiddle_fetch;

  localparam int c_N     = 8;
  localparam int c_NS    = 3;
  localparam int c_NB    = 4;
  localparam int c_PW    = 2;
  localparam int c_DW    = 16;
  localparam int c_PTR_W = c_NS * c_PW;
  localparam int c_TW_W  = c_NS * c_DW;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [c_PTR_W-1:0]  ptr_in;
  logic                inverse;
  logic                out_valid;
  logic                out_ready;
  logic [c_TW_W-1:0]   tw_real;
  logic [c_TW_W-1:0]   tw_imag;
  logic                out_last;

  twiddle_fetch #(
    .N(c_N), .NUM_STAGES(c_NS), .NUM_BUTTERFLIES(c_NB), .DATA_W(c_DW), .FRAC_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ptr_in(ptr_in), .inverse(inverse), .out_valid(out_valid),
    .out_ready(out_ready), .tw_real(tw_real), .tw_imag(tw_imag),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Reference twiddles for N=8, scale 256.
  int tbl_re [c_NB] = '{256, 181, 0, -181};
  int tbl_im [c_NB] = '{0, -181, -256, -181};

  typedef struct {
    logic [c_TW_W-1:0] re;
    logic [c_TW_W-1:0] im;
    int                acc;
    bit                strict;
  } item_t;

  item_t exp_q[$];
  int    chk = 0;
  int    fails = 0;
  int    cyc = 0;
  int    mcnt = 0;
  bit    shown = 0;
  bit    post_rst = 0;
  bit    strict_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    chk++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    chk++;
    fails++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", nm, cyc);
  endtask

  function automatic item_t model(input logic [c_PTR_W-1:0] p, input logic inv,
                                  input int acc, input bit strict);
    item_t it;
    for (int s = 0; s < c_NS; s++) begin
      int idx;
      int re;
      int im;
      idx = int'(p[s*c_PW +: c_PW]);
      re  = tbl_re[idx];
      im  = inv ? -tbl_im[idx] : tbl_im[idx];
      it.re[s*c_DW +: c_DW] = c_DW'(re);
      it.im[s*c_DW +: c_DW] = c_DW'(im);
    end
    it.acc    = acc;
    it.strict = strict;
    return it;
  endfunction

  // Monitor / scoreboard: samples on the falling edge, away from updates.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      mcnt     = 0;
      shown    = 0;
      post_rst = 1;
    end else begin
      if (post_rst) begin
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_tw_real", 64'(tw_real), 64'd0);
        check("rst_tw_imag", 64'(tw_imag), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        post_rst = 0;
      end
      // Two beats in flight means both slots are occupied.
      check("in_ready", 64'(in_ready), 64'(!(exp_q.size() >= 2 && !out_ready)));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          item_t it;
          it = exp_q[0];
          if (!shown) begin
            shown = 1;
            if (it.strict) check("latency", 64'(cyc), 64'(it.acc + 1));
            else           check("latency_min", 64'(cyc >= it.acc + 1), 64'd1);
          end
          check("tw_real", 64'(tw_real), 64'(it.re));
          check("tw_imag", 64'(tw_imag), 64'(it.im));
          check("out_last", 64'(out_last), 64'(mcnt == c_NB - 1));
          if (out_ready) begin
            void'(exp_q.pop_front());
            shown = 0;
            mcnt  = (mcnt + 1) % c_NB;
          end
        end
      end else begin
        check("out_last_idle", 64'(out_last), 64'd0);
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(ptr_in, inverse, cyc + 1, strict_lat));
    end
  end

  function automatic logic [c_PTR_W-1:0] all_ptr(input int p);
    logic [c_PTR_W-1:0] v;
    for (int s = 0; s < c_NS; s++) v[s*c_PW +: c_PW] = c_PW'(p);
    return v;
  endfunction

  task automatic send(input logic [c_PTR_W-1:0] p, input logic inv);
    bit hs;
    int n;
    hs = 0;
    n  = 0;
    in_valid = 1'b1;
    ptr_in   = p;
    inverse  = inv;
    while (!hs) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!hs && n > 50) begin
        fail_now("send_handshake");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    ptr_in    = '0;
    inverse   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Full-rate stream of the four table entries.
    strict_lat = 1;
    for (int i = 0; i < 4; i++) send(all_ptr(i), 1'b0);
    drain();

    // Backpressure for three cycles after the first output.
    strict_lat = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(all_ptr(i % 4), 1'b0);
      end
      begin
        int n;
        n = 0;
        while (n < 50) begin
          @(negedge clk);
          if (out_valid) break;
          n++;
        end
        if (n >= 50) fail_now("first_output");
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Mixed pointers with conjugation, then alternating inverse on pointer 1.
    strict_lat = 1;
    send({2'd3, 2'd2, 2'd0}, 1'b1);
    for (int i = 0; i < 4; i++) send(all_ptr(1), 1'(i % 2));
    drain();

    // Reset while two beats are in flight; the sweep restarts at zero.
    send(all_ptr(2), 1'b0);
    send(all_ptr(3), 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) send(all_ptr(i), 1'b0);
    drain();

    // Bubbles: one idle cycle between beats.
    for (int i = 0; i < 8; i++) begin
      send(all_ptr(i % 4), 1'(i % 3 == 0));
      @(posedge clk);
      #1;
    end
    drain();

    // Randomized valid/ready traffic.
    strict_lat = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      ptr_in    = c_PTR_W'($urandom);
      inverse   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

endmodule
`default_nettype wire
